toggle_hs_receiver: RTL and testbench

- Receive end of the two-phase (toggle) bundled-data handshake. The sender flips req_tgl through a T flip-flop; this block detects each req_tgl transition and captures data_in.
- Presents the captured word on a valid/ready output port.
- Returns completion by flipping ack_tgl.
- Also keeps an event counter and a sticky overrun flag for protocol violations.

---
 rtl/toggle_hs_receiver_pkg.sv | 11 +
 rtl/toggle_hs_receiver_sync.sv | 33 +++
 rtl/toggle_hs_receiver.sv | 93 +++++++++
 tb/tb_toggle_hs_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_hs_receiver_pkg.sv
// Shared types and constants for the two-phase (toggle) handshake receiver.
package toggle_hs_receiver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/toggle_hs_receiver_sync.sv
// Toggle synchronizer: N-flop chain to a level, one delay flop, and the XOR edge detect.
module toggle_sync
  import toggle_hs_receiver_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tgl,
  output logic o_lvl,
  output logic o_edge
);

  // Requests below the metastability minimum are widened rather than rejected.
  localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] r_chain;
  logic         r_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_chain <= '0;
      r_d     <= 1'b0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_tgl};
      r_d     <= r_chain[N-1];
    end
  end

  assign o_lvl  = r_chain[N-1];
  assign o_edge = r_chain[N-1] ^ r_d;

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receive side of a two-phase bundled-data handshake with valid/ready output,
// event counter and sticky overrun flag.
module toggle_hs_receiver
  import toggle_hs_receiver_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              evt_clr,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overrun
);

  hs_state_t         r_state;
  hs_state_t         w_state_nxt;
  logic              w_req_s;
  logic              w_req_edge;
  logic              w_capture;
  logic              w_consume;
  logic              w_ovr_evt;
  logic              r_ack;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk    (clk),
    .rst    (rst),
    .i_tgl  (req_tgl),
    .o_lvl  (w_req_s),
    .o_edge (w_req_edge)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    w_ovr_evt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // An edge in HOLD is dropped even when the word is consumed this cycle.
        w_ovr_evt = w_req_edge;
        if (out_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_data <= data_in;
      if (w_consume) r_ack  <= ~r_ack;
      if (evt_clr)        r_count <= '0;
      else if (w_consume) r_count <= r_count + 1'b1;
      if (evt_clr)        r_overrun <= 1'b0;
      else if (w_ovr_evt) r_overrun <= 1'b1;
    end
  end

  assign ack_tgl   = r_ack;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign evt_count = r_count;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed self-checking bench for toggle_hs_receiver (default parameters).
module tb_toggle_hs_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       evt_clr;
  logic [7:0] evt_count;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  toggle_hs_receiver #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .evt_clr   (evt_clr),
    .evt_count (evt_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_tgl = 1'b0; data_in = 8'h00; out_ready = 1'b0; evt_clr = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ack_tgl, out_valid, evt_count, overrun} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_state: ack=%b valid=%b cnt=%0d ovr=%b, required all 0",
               ack_tgl, out_valid, evt_count, overrun);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || ack_tgl !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: valid=%b ack=%b, required 0 0", i, out_valid, ack_tgl);
      end
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1; data_in = 8'hA5; req_tgl = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_early cycle %0d: valid=%b, required 0", i, out_valid);
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack_tgl !== 1'b0) begin
      n_err++;
      $display("FAIL single_valid: valid=%b data=%h ack=%b, required 1 a5 0", out_valid, out_data, ack_tgl);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || evt_count !== 8'd1) begin
      n_err++;
      $display("FAIL single_ack: valid=%b ack=%b cnt=%0d, required 0 1 1", out_valid, ack_tgl, evt_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; data_in = 8'h3C; req_tgl = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_tgl !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: valid=%b data=%h ack=%b, required 1 3c 1",
                 i, out_valid, out_data, ack_tgl);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || evt_count !== 8'd2) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ack=%b cnt=%0d, required 0 0 2", out_valid, ack_tgl, evt_count);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0; data_in = 8'h11; req_tgl = 1'b1;
    repeat (3) tick();
    data_in = 8'hFF; req_tgl = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (overrun !== 1'b1 || out_data !== 8'h11 || out_valid !== 1'b1 || ack_tgl !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_flag: ovr=%b data=%h valid=%b ack=%b, required 1 11 1 0",
               overrun, out_data, out_valid, ack_tgl);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || evt_count !== 8'd3) begin
      n_err++;
      $display("FAIL ovr_consume: valid=%b ack=%b cnt=%0d, required 0 1 3", out_valid, ack_tgl, evt_count);
    end
    repeat (6) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_lost_edge: valid=%b ack=%b ovr=%b, required 0 1 1", out_valid, ack_tgl, overrun);
    end
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || evt_count !== 8'd0 || ack_tgl !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_clear: ovr=%b cnt=%0d ack=%b, required 0 0 1", overrun, evt_count, ack_tgl);
    end
  endtask

  task automatic test_back_to_back();
    logic e_ack;
    logic seen;
    e_ack = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      data_in = i[7:0];
      req_tgl = ~req_tgl;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        tick();
        seen = out_valid;
      end
      n_cmp++;
      if (!seen || out_data !== i[7:0]) begin
        n_err++;
        $display("FAIL stream_word %0d: seen=%b data=%h, required 1 %h", i, seen, out_data, i[7:0]);
      end
      tick();
      e_ack = ~e_ack;
      n_cmp++;
      if (ack_tgl !== e_ack || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stream_ack %0d: ack=%b valid=%b, required %b 0", i, ack_tgl, out_valid, e_ack);
      end
    end
    n_cmp++;
    if (evt_count !== 8'd4 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL stream_wrap: cnt=%0d ovr=%b, required 4 0", evt_count, overrun);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0; data_in = 8'h5A; req_tgl = ~req_tgl;
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_err++;
      $display("FAIL rh_pending: valid=%b data=%h, required 1 5a", out_valid, out_data);
    end
    rst = 1'b0; req_tgl = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || out_data !== 8'h00 || evt_count !== 8'd0) begin
      n_err++;
      $display("FAIL rh_reset: valid=%b ack=%b data=%h cnt=%0d, required 0 0 00 0",
               out_valid, ack_tgl, out_data, evt_count);
    end
    out_ready = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || evt_count !== 8'd0) begin
      n_err++;
      $display("FAIL rh_no_ack: valid=%b ack=%b cnt=%0d, required 0 0 0", out_valid, ack_tgl, evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
